// File: rtl/button_pkg.sv
// Shared constants and chord-FSM state encoding for the button conditioner.
package button_pkg;

  localparam int NUM_BTN = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GATHER = 2'b01,
    ST_EMIT   = 2'b10
  } chord_state_e;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bus: raw buttons in, debounced levels, chord strobe and FSM state out.
interface button_conditioner_if;
  import button_pkg::*;

  // No handshake: control is a single-cycle strobe with no back-pressure;
  // the consumer must sample it every cycle.
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] pressed;
  logic [NUM_BTN-1:0] control;
  chord_state_e       state;

  modport master (output btn_raw, input pressed, input control, input state);
  modport slave  (input btn_raw, output pressed, output control, output state);
endinterface

// File: rtl/button_conditioner_debounce_bit.sv
// One button: 2-flop synchronizer, stability counter and debounced level.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Counter only runs while the synchronized input disagrees with the level.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces four buttons and emits a one-cycle chord code once all are released.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  logic [NUM_BTN-1:0] level;
  chord_state_e       state_q, state_d;
  logic [NUM_BTN-1:0] acc_q, acc_d;
  logic [NUM_BTN-1:0] control_q, control_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (bus.btn_raw[i]),
      .level_o(level[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    control_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (level != '0) begin
          state_d = ST_GATHER;
          acc_d   = level;
        end
      end
      ST_GATHER: begin
        acc_d = acc_q | level;
        if (level == '0) state_d = ST_EMIT;
      end
      // Presses arriving now are left for IDLE so chords never merge.
      ST_EMIT: begin
        control_d = acc_q;
        acc_d     = '0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      control_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      control_q <= control_d;
    end
  end

  assign bus.pressed = level;
  assign bus.control = control_q;
  assign bus.state   = state_q;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: stable-input cycles required before a debounced level changes (10 ms at 50 MHz).
REQ-002 Parameter CNT_W, default 19: debounce counter width; SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 btn_raw  input  4  raw push-buttons, asynchronous to clk, 1 = pressed; bit 3 = button 0, bit 2 = button 1.
REQ-006 pressed  output  4  debounced button levels, registered.
REQ-007 control  output  4  chord code, registered; nonzero for exactly one cycle per completed chord, else 4'b0000; feeds the turn-phase FSM control input.

Function
REQ-008 Each btn_raw bit SHALL pass a 2-flop synchronizer; output s[i].
REQ-009 Per bit, counter SHALL clear whenever s[i] == pressed[i].
REQ-010 Per bit, counter SHALL increment while s[i] != pressed[i].
REQ-011 When counter == DEBOUNCE_CYCLES-1 and s[i] != pressed[i], pressed[i] SHALL take s[i] next cycle and counter SHALL clear.
REQ-012 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change pressed.
REQ-013 Clean edge latency, btn_raw to pressed: 2 + DEBOUNCE_CYCLES cycles.
REQ-014 Chord FSM SHALL have states IDLE, GATHER, EMIT, plus a 4-bit accumulator acc.
REQ-015 IDLE: if pressed != 0 -> GATHER with acc <= pressed; else stay.
REQ-016 GATHER: acc <= acc | pressed each cycle; if pressed == 0 -> EMIT.
REQ-017 EMIT: control <= acc for one cycle; acc <= 0; -> IDLE.
REQ-018 Example chords: single button 0 yields 4'b1000; all four held together, in any order, yields 4'b1111.
REQ-019 Chord completion to control pulse: pressed reaching 0 in cycle N gives control nonzero in cycle N+2.
REQ-020 A press during EMIT SHALL be picked up by IDLE on the following cycle; no chord is lost or merged.
REQ-021 control SHALL be 4'b0000 in every cycle except EMIT output cycles; never two consecutive nonzero cycles.
REQ-022 Simultaneous bit changes SHALL be debounced independently; no priority between bits.
REQ-023 Unused/illegal state encodings SHALL return to IDLE with acc cleared and control 4'b0000.

Reset
REQ-024 rst asserted SHALL immediately force synchronizer flops, pressed, counters, acc and control to 0, and FSM to IDLE.
REQ-025 Reset mid-chord SHALL discard the partial chord; no control pulse after release.
REQ-026 After release, buttons already held SHALL be treated as new presses once debounced.

Structure
REQ-027 Package button_pkg SHALL hold chord-FSM state encoding (IDLE=2'b00, GATHER=2'b01, EMIT=2'b10) and button count constant NUM_BTN=4.
REQ-028 Sub-module debounce_bit (synchronizer + counter + level, parameterised by DEBOUNCE_CYCLES/CNT_W) SHALL be instantiated NUM_BTN times; chord FSM stays in top level.

Verification (DEBOUNCE_CYCLES=4, CNT_W=3)
REQ-029 Hold btn_raw=4'b1000 for 20 cycles then 0 -> pressed[3] rises 6 cycles after the edge; exactly one control=4'b1000 pulse after release.
REQ-030 btn_raw[2] pulses 1 for 3 cycles, 5 times with gaps of 3 -> pressed stays 0; control stays 0.
REQ-031 Press bits 3,2,1,0 staggered by 2 cycles, release staggered -> single control=4'b1111 pulse.
REQ-032 Assert rst while in GATHER with acc=4'b0100 -> all outputs 0 immediately; no pulse after buttons release.
REQ-033 New press of button 1 whose debounce completes on the EMIT cycle of a prior 4'b1000 chord -> pulses 4'b1000 then 4'b0100, separated by at least one zero cycle.
